mult_div_unit: RTL and testbench

- Parametrised multicycle multiply/divide engine that produces the HI/LO results for the multicycle CPU datapath.
- Operands come from the A and B register outputs; results load the HI and LO registers.
- Products and quotients are computed iteratively, one bit per cycle, using shift-add multiplication and restoring division, with sign correction.
- A start/busy/done handshake lets the control unit stall until the result is ready.

---
 rtl/mult_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle multiply/divide engine feeding the HI/LO registers of the
//   multicycle CPU datapath. One product/quotient bit is resolved per cycle:
//   shift-add multiplication or restoring division on operand magnitudes,
//   followed by a single sign-correction cycle.
//
//   Optional feature macro: MULTDIV_UNSIGNED_EN
//     defined   : op[1] = 1 selects multu/divu (no sign handling)
//     undefined : op[1] is ignored, every operation is signed
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   request a new operation (sampled only when idle)
//   op[1:0]  in   op[0]: 0 mult / 1 div, op[1]: unsigned (macro only)
//   a, b     in   operands, captured on the accepted start edge
//   hi       out  product upper half / remainder
//   lo       out  product lower half / quotient
//   busy     out  high whenever the unit is not idle
//   done     out  one-cycle pulse when hi/lo update or div-by-zero flags
//   div_zero out  set with done for b = 0 divides, cleared on next start
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  // Shared working register.
  //   mult: {partial product, remaining multiplier bits}
  //   div : {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               sign_a;   // captured operand signs (0 when unsigned)
  logic               sign_b;
  logic               dz;       // current operation is a divide by zero

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic is_signed;
`ifdef MULTDIV_UNSIGNED_EN
  assign is_signed = ~op[1];
`else
  logic unused_op1;
  assign is_signed  = 1'b1;
  assign unused_op1 = op[1];
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  // The most-negative value maps onto itself, which is the correct
  // unsigned magnitude, so no special case is needed.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // ---------------------------------------------------------------------------
  // Iteration steps
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mult_next;

  assign msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mult_next = {msum, acc[WIDTH-1:1]};

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_next;

  // Remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and diff[WIDTH] is a reliable borrow/negative flag.
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign div_next = {rem_next, acc[WIDTH-2:0], ~diff[WIDTH]};

  // ---------------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[0];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            count    <= '0;
            div_zero <= 1'b0;
            opnd     <= op[0] ? b_mag : a_mag;
            acc      <= op[0] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            // A divide by zero skips the iterations but still passes
            // through FIX, so its done pulse lands one edge after start
            // with the same one-cycle DONE tail as a normal finish.
            if (op[0] && (b == '0)) begin
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mult_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          state <= DONE;
          if (dz) begin
            div_zero <= 1'b1;          // hi/lo deliberately left untouched
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;        // DONE: one cycle, start ignored
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no pending operation at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", {32'h0, hi}, {32'h0, mon_e.hi});
        chk("lo", {32'h0, lo}, {32'h0, mon_e.lo});
        chk("div_zero", {63'h0, div_zero}, {63'h0, mon_e.dz});
        chk("done_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Issue one operation, push its expected result, wait for completion.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input int lat, output int k);
    exp_t e;
    bit   fin;
    @(negedge clock);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clock);
    #1;
    k = cyc;
    e.hi = eh; e.lo = el; e.dz = edz; e.due = k + lat;
    sb_q.push_back(e);
    // Disturb inputs: the unit must work from its captured copies.
    start = 1'b0; op = ~o; a = 32'hDEADBEEF; b = 32'h0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    chk("div_zero_cleared", {63'h0, div_zero}, 64'h0);
    fin = 1'b0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clock);
      #1;
      if (busy !== 1'b1) begin
        chk("busy_held", {63'h0, busy}, 64'h1);
      end
      if (sb_q.size() == 0) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 60 cycles of start at cycle %0d", k);
      sb_q.delete();
    end
  endtask

  int k0, k1;

  initial begin
    // Reset state
    #12;
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_div_zero", {63'h0, div_zero}, 64'h0);
    @(negedge clock);
    reset = 1'b1;

    // signed mult 7 * -3 = -21
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, k0);
    // signed div -7 / 2 -> q -3, r -1 (issued back to back)
    issue(2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, k1);
    chk("throughput", 64'(k1 - k0), 64'(W + 3));
    // divide by zero: hi/lo keep the previous result
    issue(2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1, k0);
    // most-negative / -1 wraps
    issue(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, k0);
    // large positive product
    issue(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33, k0);
    // 100 / -7 -> q -14, r 2
    issue(2'b01, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33, k0);
    // -1 * -1 = 1
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, k0);
    // -100 / -7 -> q 14, r -2
    issue(2'b01, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33, k0);

    // Reset in the middle of RUN (count 10)
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'd123; b = 32'd456;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_hi", {32'h0, hi}, 64'h0);
    chk("abort_lo", {32'h0, lo}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_div_zero", {63'h0, div_zero}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    issue(2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, k0);

    // zero product
    issue(2'b00, 32'd0, 32'd12345, 32'h0, 32'h0, 1'b0, 33, k0);
`ifdef MULTDIV_UNSIGNED_EN
    issue(2'b10, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, k0);
    issue(2'b11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'h7FFFFFFF, 1'b0, 33, k0);
`else
    issue(2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, k0);
    issue(2'b11, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, k0);
`endif

    repeat (4) @(negedge clock);
    chk("idle_at_end", {63'h0, busy}, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
